// File: rtl/prores_vlc_pkg.sv
// Shared types for the ProRes VLC bitstream scheduler.
//   codeword_t    : one buffered codeword (value, bit length, last-level marker)
//   sched_state_e : slice sequencing states
//   CW_VAL_W/CW_LEN_W : default codeword field widths
//   SRC_*         : source index into the per-source FIFO bank
package prores_vlc_pkg;
  localparam int CW_VAL_W = 32;
  localparam int CW_LEN_W = 6;

  localparam int NUM_SRC = 3;
  localparam int SRC_DC  = 0;
  localparam int SRC_RUN = 1;
  localparam int SRC_LVL = 2;

  typedef struct packed {
    logic [CW_VAL_W-1:0] val;
    logic [CW_LEN_W-1:0] size;
    logic                last;
  } codeword_t;

  typedef enum logic [2:0] {
    IDLE, DC, AC_RUN, AC_LVL, FLUSH, DONE
  } sched_state_e;
endpackage

// File: rtl/vlc_code_fifo.sv
// Codeword FIFO, one per entropy source.
//   clock/reset_n : clock, async active-low reset
//   clr           : synchronous clear (wins over push/pop)
//   push/din      : write; ignored when full
//   pop           : advance head; ignored when empty
//   head          : current head entry, combinational
//   full/empty    : occupancy flags
module vlc_code_fifo
  import prores_vlc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      clr,
  input  logic      push,
  input  codeword_t din,
  input  logic      pop,
  output codeword_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  codeword_t        mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/vlc_bitstream_scheduler.sv
// Sequences slice codewords into the set_bit packer in ProRes order:
// block_num DC codewords, then AC run/level pairs (run first) until the
// level marked last, then one flush request, then a slice_done pulse.
// Ports:
//   clock, reset_n               : clock, async active-low reset
//   slice_start, block_num       : start/restart a slice, DC count for it
//   dc_*/run_*/lvl_*             : source handshakes (valid/ready/val/size), lvl_last
//   out_enable/out_ready         : registered codeword toward set_bit
//   out_val/out_size_of_bit      : codeword value / bit length (clamped to VAL_W)
//   out_flush_bit                : flush request (val/size are 0)
//   slice_done                   : 1-cycle pulse after flush accepted
//   err_overflow/err_length      : sticky error flags, cleared on slice_start
// Optional (define VLC_SCHED_STATS_EN):
//   stat_bits, stat_codewords    : saturating sum of sizes / count of accepted codewords
module vlc_bitstream_scheduler
  import prores_vlc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int VAL_W      = CW_VAL_W,
  parameter int LEN_W      = CW_LEN_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             slice_start,
  input  logic [31:0]      block_num,
  input  logic             dc_valid,
  output logic             dc_ready,
  input  logic [VAL_W-1:0] dc_val,
  input  logic [LEN_W-1:0] dc_size,
  input  logic             run_valid,
  output logic             run_ready,
  input  logic [VAL_W-1:0] run_val,
  input  logic [LEN_W-1:0] run_size,
  input  logic             lvl_valid,
  output logic             lvl_ready,
  input  logic [VAL_W-1:0] lvl_val,
  input  logic [LEN_W-1:0] lvl_size,
  input  logic             lvl_last,
  output logic             out_enable,
  input  logic             out_ready,
  output logic [VAL_W-1:0] out_val,
  output logic [LEN_W-1:0] out_size_of_bit,
  output logic             out_flush_bit,
  output logic             slice_done,
  output logic             err_overflow,
  output logic             err_length
`ifdef VLC_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_bits,
  output logic [31:0]      stat_codewords
`endif
);
  localparam logic [LEN_W-1:0] MAX_SIZE = LEN_W'(VAL_W);

  sched_state_e         state, state_n;
  codeword_t            fifo_din  [NUM_SRC];
  codeword_t            fifo_head [NUM_SRC];
  logic [NUM_SRC-1:0]   src_valid, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]          dc_cnt, blk_q;
  codeword_t            pop_cw;
  logic [LEN_W-1:0]     pop_size;
  logic                 mid_slice, abort, can_load, load_flush, flush_acc;

  assign src_valid = {lvl_valid, run_valid, dc_valid};
  assign fifo_din[SRC_DC]  = '{val: dc_val,  size: dc_size,  last: 1'b0};
  assign fifo_din[SRC_RUN] = '{val: run_val, size: run_size, last: 1'b0};
  assign fifo_din[SRC_LVL] = '{val: lvl_val, size: lvl_size, last: lvl_last};

  // A restart only discards buffered data when a slice is actually in flight;
  // data pushed while IDLE/DONE belongs to the slice being started.
  assign mid_slice = (state == DC) || (state == AC_RUN) || (state == AC_LVL) || (state == FLUSH);
  assign abort     = slice_start && mid_slice;

  assign fifo_push = src_valid & ~fifo_full & {NUM_SRC{~abort}};
  assign dc_ready  = ~fifo_full[SRC_DC];
  assign run_ready = ~fifo_full[SRC_RUN];
  assign lvl_ready = ~fifo_full[SRC_LVL];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    vlc_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock  (clock),
      .reset_n(reset_n),
      .clr    (abort),
      .push   (fifo_push[i]),
      .din    (fifo_din[i]),
      .pop    (fifo_pop[i]),
      .head   (fifo_head[i]),
      .full   (fifo_full[i]),
      .empty  (fifo_empty[i])
    );
  end

  // Head selected by state (not by pop) so pop decisions never loop back.
  always_comb begin
    pop_cw = fifo_head[SRC_LVL];
    if (state == DC)          pop_cw = fifo_head[SRC_DC];
    else if (state == AC_RUN) pop_cw = fifo_head[SRC_RUN];
  end
  assign pop_size = (pop_cw.size > MAX_SIZE) ? MAX_SIZE : pop_cw.size;

  // Output register is free when empty or being accepted this cycle.
  assign can_load = !out_enable || out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    fifo_pop   = '0;
    load_flush = 1'b0;
    flush_acc  = 1'b0;
    if (slice_start) begin
      state_n = (block_num == 32'd0) ? FLUSH : DC;
    end else begin
      case (state)
        DC: if (can_load && !fifo_empty[SRC_DC]) begin
          fifo_pop[SRC_DC] = 1'b1;
          if (dc_cnt == blk_q - 32'd1) state_n = AC_RUN;
        end
        AC_RUN: if (can_load && !fifo_empty[SRC_RUN]) begin
          fifo_pop[SRC_RUN] = 1'b1;
          state_n           = AC_LVL;
        end
        AC_LVL: if (can_load && !fifo_empty[SRC_LVL]) begin
          fifo_pop[SRC_LVL] = 1'b1;
          state_n           = pop_cw.last ? FLUSH : AC_RUN;
        end
        FLUSH: begin
          if (out_enable && out_flush_bit) begin
            if (out_ready) begin
              flush_acc = 1'b1;
              state_n   = DONE;
            end
          end else if (can_load) begin
            load_flush = 1'b1;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign slice_done = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_enable      <= 1'b0;
      out_val         <= '0;
      out_size_of_bit <= '0;
      out_flush_bit   <= 1'b0;
      dc_cnt          <= '0;
      blk_q           <= '0;
      err_overflow    <= 1'b0;
      err_length      <= 1'b0;
    end else if (slice_start) begin
      out_enable      <= 1'b0;
      out_val         <= '0;
      out_size_of_bit <= '0;
      out_flush_bit   <= 1'b0;
      dc_cnt          <= '0;
      blk_q           <= block_num;
      err_overflow    <= 1'b0;
      err_length      <= 1'b0;
    end else begin
      if (out_enable && out_ready) begin
        out_enable    <= 1'b0;
        out_flush_bit <= 1'b0;
      end
      if (fifo_pop[SRC_DC]) dc_cnt <= dc_cnt + 32'd1;
      // Zero-length codewords are consumed for sequencing but never emitted.
      if (|fifo_pop && pop_cw.size != '0) begin
        out_enable      <= 1'b1;
        out_val         <= pop_cw.val;
        out_size_of_bit <= pop_size;
        out_flush_bit   <= 1'b0;
      end
      if (load_flush) begin
        out_enable      <= 1'b1;
        out_val         <= '0;
        out_size_of_bit <= '0;
        out_flush_bit   <= 1'b1;
      end
      if (flush_acc) out_flush_bit <= 1'b0;
      if (|(src_valid & fifo_full))             err_overflow <= 1'b1;
      if (|fifo_pop && pop_cw.size > MAX_SIZE)  err_length   <= 1'b1;
    end
  end

`ifdef VLC_SCHED_STATS_EN
  logic [32:0] bits_sum;
  assign bits_sum = {1'b0, stat_bits} + 33'(out_size_of_bit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_bits      <= '0;
      stat_codewords <= '0;
    end else if (slice_start) begin
      stat_bits      <= '0;
      stat_codewords <= '0;
    end else if (out_enable && out_ready && !out_flush_bit) begin
      stat_bits <= bits_sum[32] ? '1 : bits_sum[31:0];
      if (stat_codewords != '1) stat_codewords <= stat_codewords + 32'd1;
    end
  end
`endif
endmodule
